// File: rtl/phy_pkg.sv
// Shared PHY symbols, receiver state encoding and lock defaults.
package phy_pkg;
    localparam logic [7:0] COM_SYM        = 8'hBC;
    localparam logic [7:0] IDL_SYM        = 8'h7C;
    localparam logic [1:0] HUNT           = 2'd0;
    localparam logic [1:0] LOCKING        = 2'd1;
    localparam logic [1:0] ACTIVE         = 2'd2;
    localparam int         LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_HUNT    = HUNT,
        ST_LOCKING = LOCKING,
        ST_ACTIVE  = ACTIVE
    } rx_state_e;
endpackage

// File: rtl/phy_rx_lock_fsm.sv
// Byte-alignment lock FSM: hunts for COM at any bit offset, then confirms
// LOCK_COUNT consecutive COMs on byte boundaries before declaring the lane active.
import phy_pkg::*;

module phy_rx_lock_fsm #(
    parameter logic [7:0] COM        = COM_SYM,
    parameter int          LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic [7:0] word_i,
    input  logic       boundary_i,
    output rx_state_e  state_o,
    output logic       active_o,
    output logic       cnt_clr_o
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    rx_state_e  state_q;
    logic [3:0] com_cnt_q;
    logic       active_q;
    logic       is_com;
    logic [3:0] com_cnt_inc;

    assign is_com      = (word_i == COM);
    assign com_cnt_inc = com_cnt_q + 4'd1;

    always_ff @(posedge clk16) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            com_cnt_q <= 4'd0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (is_com) begin
                        com_cnt_q <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state_q  <= ST_ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOCKING;
                        end
                    end
                end
                ST_LOCKING: begin
                    if (boundary_i) begin
                        if (is_com) begin
                            // com_cnt never passes LOCK_N: reaching it leaves LOCKING
                            com_cnt_q <= com_cnt_inc;
                            if (com_cnt_inc == LOCK_N) begin
                                state_q  <= ST_ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_HUNT;
                            com_cnt_q <= 4'd0;
                        end
                    end
                end
                ST_ACTIVE: ;
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    // Holding bit_cnt at 0 while hunting aligns it to the matching edge.
    assign cnt_clr_o = (state_q == ST_HUNT);
    assign state_o   = state_q;
    assign active_o  = active_q;
endmodule

// File: rtl/phy_serial_rx.sv
// Single-lane serial-to-parallel receiver: shift register, bit counter and
// registered {valid, byte} output; alignment is delegated to phy_rx_lock_fsm.
import phy_pkg::*;

module phy_serial_rx #(
    parameter logic [7:0] COM        = COM_SYM,
    parameter int          LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic       data_in,
    output logic [8:0] data_out,
    output logic       byte_strobe,
    output logic       active
);
    // Only the 7 most recent bits are ever needed; the candidate word appends data_in.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [8:0] data_out_q;
    logic       strobe_q;
    logic [7:0] word;
    logic       boundary;
    logic       cnt_clr;
    logic       emit;
    rx_state_e  state;

    assign word     = {sr_q, data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign emit     = (state == ST_ACTIVE) && boundary;

    phy_rx_lock_fsm #(
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clk16      (clk16),
        .reset      (reset),
        .word_i     (word),
        .boundary_i (boundary),
        .state_o    (state),
        .active_o   (active),
        .cnt_clr_o  (cnt_clr)
    );

    always_ff @(posedge clk16) begin
        if (reset) begin
            sr_q       <= 7'd0;
            bit_cnt_q  <= 3'd0;
            data_out_q <= 9'h000;
            strobe_q   <= 1'b0;
        end else begin
            sr_q      <= word[6:0];
            bit_cnt_q <= cnt_clr ? 3'd0 : bit_cnt_q + 3'd1;
            strobe_q  <= emit;
            if (emit)
                data_out_q <= (word == COM) ? 9'h000 : {1'b1, word};
        end
    end

    assign data_out    = data_out_q;
    assign byte_strobe = strobe_q;
endmodule

// File: tb/tb_phy_serial_rx.sv
// Directed bench for phy_serial_rx: lock, decode, loss of alignment, reset cases.
module tb_phy_serial_rx;
    logic       clk16 = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic [8:0] data_out;
    logic       byte_strobe;
    logic       active;

    int total = 0, bad = 0;
    int edge_n = 0, strobe_cnt = 0, last_strb = 0, act_edge = 0;

    phy_serial_rx #(.COM(8'hBC), .LOCK_COUNT(4)) dut (
        .clk16       (clk16),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk16 = ~clk16;

    task automatic bit_in(input logic b);
        @(negedge clk16);
        data_in = b;
        @(posedge clk16);
        #1;
        edge_n++;
        if (byte_strobe) begin
            strobe_cnt++;
            last_strb = edge_n;
        end
        if (active && act_edge == 0) act_edge = edge_n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_in(b[i]);
    endtask

    // One reset edge carrying bit b; edge numbering restarts after it.
    task automatic reset_edge(input logic b);
        @(negedge clk16);
        data_in = b;
        reset   = 1'b1;
        @(posedge clk16);
        #1;
        @(negedge clk16);
        reset      = 1'b0;
        edge_n     = 0;
        strobe_cnt = 0;
        last_strb  = 0;
        act_edge   = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk16);
        #1;
        total++; if (data_out !== 9'h000) begin bad++; $display("FAIL reset_data_out: got %h want 000", data_out); end
        total++; if (byte_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", byte_strobe); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    endtask

    task automatic test_lock_aligned;
        reset_edge(1'b0);
        repeat (4) send_byte(8'hBC);
        total++; if (strobe_cnt !== 0) begin bad++; $display("FAIL lock_no_strobe: got %0d strobes want 0", strobe_cnt); end
        total++; if (act_edge !== 32) begin bad++; $display("FAIL lock_active_edge: got %0d want 32", act_edge); end
        send_byte(8'hBC);
        total++; if (last_strb !== 40 || strobe_cnt !== 1) begin bad++; $display("FAIL lock_first_strobe: got edge %0d cnt %0d want edge 40 cnt 1", last_strb, strobe_cnt); end
        total++; if (data_out !== 9'h000) begin bad++; $display("FAIL lock_com_word: got %h want 000", data_out); end
    endtask

    task automatic test_data;
        logic [7:0] bytes [4];
        logic [8:0] exp   [4];
        bytes = '{8'hA5, 8'h3C, 8'hBC, 8'hFF};
        exp   = '{9'h1A5, 9'h13C, 9'h000, 9'h1FF};
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            total++; if (byte_strobe !== 1'b1 || last_strb !== 48 + 8 * i) begin bad++; $display("FAIL data_strobe_%0d: got strobe %b edge %0d want 1 edge %0d", i, byte_strobe, last_strb, 48 + 8 * i); end
            total++; if (data_out !== exp[i]) begin bad++; $display("FAIL data_word_%0d: got %h want %h", i, data_out, exp[i]); end
        end
    endtask

    task automatic test_offset;
        reset_edge(1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        repeat (4) send_byte(8'hBC);
        total++; if (act_edge !== 35) begin bad++; $display("FAIL offset_active_edge: got %0d want 35", act_edge); end
        send_byte(8'h5A);
        total++; if (last_strb !== 43 || data_out !== 9'h15A) begin bad++; $display("FAIL offset_decode: got edge %0d word %h want edge 43 word 15a", last_strb, data_out); end
        send_byte(8'hBC);
        total++; if (last_strb !== 51 || data_out !== 9'h000) begin bad++; $display("FAIL offset_com: got edge %0d word %h want edge 51 word 000", last_strb, data_out); end
    endtask

    task automatic test_break;
        reset_edge(1'b0);
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h55);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL break_active_at_24: got %b want 0", active); end
        repeat (3) send_byte(8'hBC);
        total++; if (act_edge !== 0) begin bad++; $display("FAIL break_early_lock: got active at edge %0d want none by 48", act_edge); end
        send_byte(8'hBC);
        total++; if (act_edge !== 56 || strobe_cnt !== 0) begin bad++; $display("FAIL break_relock: got edge %0d strobes %0d want edge 56 strobes 0", act_edge, strobe_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        send_byte(8'h12);
        total++; if (data_out !== 9'h112) begin bad++; $display("FAIL mid_pre_word: got %h want 112", data_out); end
        b = 8'h96;
        for (int i = 7; i >= 5; i--) bit_in(b[i]);
        reset_edge(b[4]);
        total++; if (active !== 1'b0 || byte_strobe !== 1'b0 || data_out !== 9'h000) begin bad++; $display("FAIL mid_reset_outputs: got act %b strb %b word %h want 0 0 000", active, byte_strobe, data_out); end
        repeat (4) send_byte(8'hBC);
        total++; if (act_edge !== 32 || strobe_cnt !== 0) begin bad++; $display("FAIL mid_relock: got edge %0d strobes %0d want edge 32 strobes 0", act_edge, strobe_cnt); end
        send_byte(8'h44);
        total++; if (data_out !== 9'h144) begin bad++; $display("FAIL bnd_pre_word: got %h want 144", data_out); end
        b = 8'h33;
        for (int i = 7; i >= 1; i--) bit_in(b[i]);
        reset_edge(b[0]);
        total++; if (active !== 1'b0 || byte_strobe !== 1'b0 || data_out !== 9'h000) begin bad++; $display("FAIL bnd_reset_outputs: got act %b strb %b word %h want 0 0 000", active, byte_strobe, data_out); end
        repeat (3) send_byte(8'hBC);
        total++; if (act_edge !== 0) begin bad++; $display("FAIL bnd_early_lock: got active at edge %0d want none", act_edge); end
        send_byte(8'hBC);
        total++; if (act_edge !== 32 || strobe_cnt !== 0) begin bad++; $display("FAIL bnd_relock: got edge %0d strobes %0d want edge 32 strobes 0", act_edge, strobe_cnt); end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       v;
        logic [8:0] exp;
        int         prev;
        reset_edge(1'b0);
        repeat (4) send_byte(8'hBC);
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = 8'($urandom_range(0, 255));
            if (b == 8'hBC) b = 8'h5A;
            exp = v ? {1'b1, b} : 9'h000;
            send_byte(v ? b : 8'hBC);
            total++; if (byte_strobe !== 1'b1 || data_out !== exp) begin bad++; $display("FAIL rand_word_%0d: got strb %b word %h want 1 %h", i, byte_strobe, data_out, exp); end
            if (prev != 0) begin
                total++; if (last_strb - prev !== 8) begin bad++; $display("FAIL rand_period_%0d: got %0d want 8", i, last_strb - prev); end
            end
            prev = last_strb;
        end
        total++; if (strobe_cnt !== 20) begin bad++; $display("FAIL rand_strobe_count: got %0d want 20", strobe_cnt); end
    endtask

    initial begin
        test_reset;
        test_lock_aligned;
        test_data;
        test_offset;
        test_break;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
